// File: rtl/sc_count_ctrl.sv
// Counter control FSM: turns the debounced button into SHORT/LONG commands and drives the
// counter's enable/clear strobes. Optional wrap-around mode: define COUNTCTRL_AUTORELOAD_EN.
module sc_count_ctrl #(
  parameter int N_HOLD      = 26,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       SC_COUNTCTRL_CLOCK_50,
  input  logic       SC_COUNTCTRL_RESET_InLow,
  input  logic       SC_COUNTCTRL_BUTTON_InLow,
  input  logic       SC_COUNTCTRL_TICK_InHigh,
  input  logic       SC_COUNTCTRL_FLAG_InLow,
  output logic       SC_COUNTCTRL_ENABLE_OutLow,
  output logic       SC_COUNTCTRL_CLEAR_OutLow,
  output logic [1:0] SC_COUNTCTRL_STATE_OutBus,
  output logic       SC_COUNTCTRL_DONE_OutHigh
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [N_HOLD-1:0] HOLD_MAX  = N_HOLD'(HOLD_CYCLES);
  localparam logic [N_HOLD-1:0] HOLD_LAST = N_HOLD'(HOLD_CYCLES - 1);

  state_t              state_q, state_d;
  logic                btn_q, btn_d;
  logic [N_HOLD-1:0]   hold_q, hold_d;
  logic                long_fired_q, long_fired_d;
  logic                enable_q, enable_d;
  logic                clear_q, clear_d;
  logic                long_evt, short_evt;
`ifndef COUNTCTRL_AUTORELOAD_EN
  logic                done_q, done_d;
`endif

  // Press classification. hold_q is non-zero on the first released cycle of any press,
  // so it doubles as the release detector without a second button flop.
  always_comb begin
    btn_d        = SC_COUNTCTRL_BUTTON_InLow;
    hold_d       = hold_q;
    long_fired_d = long_fired_q;
    long_evt     = 1'b0;
    short_evt    = 1'b0;
    if (!btn_q) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
      end
      if (!long_fired_q && (hold_q == HOLD_LAST)) begin
        long_evt     = 1'b1;
        long_fired_d = 1'b1;
      end
    end else if (hold_q != '0) begin
      short_evt    = !long_fired_q;
      hold_d       = '0;
      long_fired_d = 1'b0;
    end
  end

  // Next state and strobes; priority LONG > flag > SHORT > tick.
  always_comb begin
    state_d  = state_q;
    enable_d = 1'b1;
    clear_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (long_evt) begin
          clear_d = 1'b0;
        end else if (short_evt) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (long_evt) begin
          clear_d = 1'b0;
          state_d = ST_IDLE;
        end else if (!SC_COUNTCTRL_FLAG_InLow) begin
`ifdef COUNTCTRL_AUTORELOAD_EN
          // The flag can still read 0 while the clear lands; skip back-to-back clears.
          clear_d = !clear_q;
`else
          state_d = ST_DONE;
`endif
        end else if (short_evt) begin
          state_d = ST_PAUSE;
        end else if (SC_COUNTCTRL_TICK_InHigh) begin
          enable_d = 1'b0;
        end
      end
      ST_PAUSE: begin
        if (long_evt) begin
          clear_d = 1'b0;
          state_d = ST_IDLE;
        end else if (short_evt) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (long_evt || short_evt) begin
          clear_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef COUNTCTRL_AUTORELOAD_EN
  always_comb begin
    done_d = (state_d == ST_DONE);
  end
`endif

  always_ff @(posedge SC_COUNTCTRL_CLOCK_50 or negedge SC_COUNTCTRL_RESET_InLow) begin
    if (!SC_COUNTCTRL_RESET_InLow) begin
      state_q      <= ST_IDLE;
      btn_q        <= 1'b1;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      enable_q     <= 1'b1;
      clear_q      <= 1'b1;
`ifndef COUNTCTRL_AUTORELOAD_EN
      done_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      btn_q        <= btn_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      enable_q     <= enable_d;
      clear_q      <= clear_d;
`ifndef COUNTCTRL_AUTORELOAD_EN
      done_q       <= done_d;
`endif
    end
  end

  assign SC_COUNTCTRL_ENABLE_OutLow = enable_q;
  assign SC_COUNTCTRL_CLEAR_OutLow  = clear_q;
  assign SC_COUNTCTRL_STATE_OutBus  = state_q;
`ifdef COUNTCTRL_AUTORELOAD_EN
  assign SC_COUNTCTRL_DONE_OutHigh  = 1'b0;
`else
  assign SC_COUNTCTRL_DONE_OutHigh  = done_q;
`endif

endmodule

// File: tb/tb_sc_count_ctrl.sv
// Directed bench for sc_count_ctrl with HOLD_CYCLES = 8; covers both COUNTCTRL_AUTORELOAD_EN builds.
module tb_sc_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       tick;
  logic       flag;
  logic       enable_n;
  logic       clear_n;
  logic [1:0] state;
  logic       done;

  int checks;
  int failures;

  sc_count_ctrl #(
    .N_HOLD      (4),
    .HOLD_CYCLES (8)
  ) dut (
    .SC_COUNTCTRL_CLOCK_50      (clk),
    .SC_COUNTCTRL_RESET_InLow   (rst_n),
    .SC_COUNTCTRL_BUTTON_InLow  (btn),
    .SC_COUNTCTRL_TICK_InHigh   (tick),
    .SC_COUNTCTRL_FLAG_InLow    (flag),
    .SC_COUNTCTRL_ENABLE_OutLow (enable_n),
    .SC_COUNTCTRL_CLEAR_OutLow  (clear_n),
    .SC_COUNTCTRL_STATE_OutBus  (state),
    .SC_COUNTCTRL_DONE_OutHigh  (done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // enable and clear must never be low together
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!enable_n && !clear_n) begin
        failures++;
        $display("FAIL strobe_overlap: enable=%b clear=%b required not both 0", enable_n, clear_n);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the button for n cycles and releases; returns in the cycle the SHORT decision is made.
  task automatic press_short(input int n);
    btn = 1'b0;
    repeat (n) step();
    btn = 1'b1;
    step();
  endtask

  task automatic long_to_idle();
    btn = 1'b0;
    repeat (9) step();
    btn = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    flag  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick = i[0];
      step();
      checks++;
      if ({enable_n, clear_n, state, done} !== 5'b11000) begin
        failures++;
        $display("FAIL reset_outputs: got en=%b clr=%b st=%b done=%b required 1 1 00 0",
                 enable_n, clear_n, state, done);
      end
    end
    tick  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_hold_through_reset();
    for (int j = 1; j <= 8; j++) begin
      step();
      checks++;
      if (clear_n !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold_early: cycle %0d clear=%b required 1", j, clear_n);
      end
    end
    step();
    checks++;
    if (clear_n !== 1'b0 || state !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold_long: clear=%b state=%b required 0 00", clear_n, state);
    end
    step();
    checks++;
    if (clear_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_hold_once: clear=%b required 1", clear_n);
    end
    btn = 1'b1;
    repeat (3) step();
    checks++;
    if (state !== 2'b00 || clear_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_hold_noshort: state=%b clear=%b required 00 1", state, clear_n);
    end
  endtask

  task automatic test_short_press_run();
    press_short(3);
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL short_latency: state=%b required 00", state);
    end
    step();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL short_to_run: state=%b required 01", state);
    end
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      checks++;
      if (enable_n !== 1'b0) begin
        failures++;
        $display("FAIL run_tick_enable: tick %0d enable=%b required 0", k, enable_n);
      end
      step();
      checks++;
      if (enable_n !== 1'b1) begin
        failures++;
        $display("FAIL run_tick_width: tick %0d enable=%b required 1", k, enable_n);
      end
    end
  endtask

  task automatic test_long_press_run();
    btn = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      checks++;
      if (clear_n !== 1'b1 || state !== 2'b01) begin
        failures++;
        $display("FAIL long_early: cycle %0d clear=%b state=%b required 1 01", j, clear_n, state);
      end
    end
    step();
    checks++;
    if (clear_n !== 1'b0 || state !== 2'b00) begin
      failures++;
      $display("FAIL long_clear: clear=%b state=%b required 0 00", clear_n, state);
    end
    step();
    step();
    checks++;
    if (clear_n !== 1'b1) begin
      failures++;
      $display("FAIL long_once: clear=%b required 1", clear_n);
    end
    btn = 1'b1;
    repeat (3) step();
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL long_noshort: state=%b required 00", state);
    end
  endtask

  task automatic test_flag_idle();
    flag = 1'b0;
    repeat (3) step();
    checks++;
    if (state !== 2'b00 || clear_n !== 1'b1) begin
      failures++;
      $display("FAIL flag_idle: state=%b clear=%b required 00 1", state, clear_n);
    end
    press_short(2);
    step();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL flag_enter_run: state=%b required 01", state);
    end
    step();
    flag = 1'b1;
`ifdef COUNTCTRL_AUTORELOAD_EN
    checks++;
    if (clear_n !== 1'b0 || state !== 2'b01 || done !== 1'b0) begin
      failures++;
      $display("FAIL flag_enter_reload: clear=%b state=%b done=%b required 0 01 0", clear_n, state, done);
    end
    long_to_idle();
`else
    checks++;
    if (state !== 2'b11 || done !== 1'b1) begin
      failures++;
      $display("FAIL flag_enter_done: state=%b done=%b required 11 1", state, done);
    end
    press_short(2);
    step();
`endif
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL flag_back_idle: state=%b required 00", state);
    end
  endtask

  task automatic test_flag_tick();
    press_short(2);
    step();
    tick = 1'b1;
    flag = 1'b0;
    step();
    tick = 1'b0;
    flag = 1'b1;
`ifdef COUNTCTRL_AUTORELOAD_EN
    checks++;
    if (enable_n !== 1'b1 || clear_n !== 1'b0 || state !== 2'b01 || done !== 1'b0) begin
      failures++;
      $display("FAIL reload_clear: en=%b clr=%b st=%b done=%b required 1 0 01 0",
               enable_n, clear_n, state, done);
    end
    step();
    checks++;
    if (clear_n !== 1'b1 || state !== 2'b01) begin
      failures++;
      $display("FAIL reload_stay: clear=%b state=%b required 1 01", clear_n, state);
    end
    long_to_idle();
`else
    checks++;
    if (enable_n !== 1'b1 || state !== 2'b11 || done !== 1'b1) begin
      failures++;
      $display("FAIL flag_tick_done: en=%b st=%b done=%b required 1 11 1", enable_n, state, done);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (enable_n !== 1'b1 || state !== 2'b11) begin
      failures++;
      $display("FAIL done_tick_ignored: en=%b st=%b required 1 11", enable_n, state);
    end
    press_short(2);
    step();
    checks++;
    if (clear_n !== 1'b0 || state !== 2'b00 || done !== 1'b0) begin
      failures++;
      $display("FAIL done_short_clear: clr=%b st=%b done=%b required 0 00 0", clear_n, state, done);
    end
    step();
`endif
    checks++;
    if (clear_n !== 1'b1 || state !== 2'b00) begin
      failures++;
      $display("FAIL flag_tick_idle: clear=%b state=%b required 1 00", clear_n, state);
    end
  endtask

  task automatic test_pause();
    press_short(3);
    step();
    press_short(3);
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (state !== 2'b10 || enable_n !== 1'b1) begin
      failures++;
      $display("FAIL pause_enter: state=%b enable=%b required 10 1", state, enable_n);
    end
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      checks++;
      if (enable_n !== 1'b1 || state !== 2'b10) begin
        failures++;
        $display("FAIL pause_tick_ignored: tick %0d enable=%b state=%b required 1 10", k, enable_n, state);
      end
    end
    press_short(2);
    step();
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL pause_resume: state=%b required 01", state);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (enable_n !== 1'b0) begin
      failures++;
      $display("FAIL resume_tick: enable=%b required 0", enable_n);
    end
    step();
    checks++;
    if (enable_n !== 1'b1) begin
      failures++;
      $display("FAIL resume_tick_width: enable=%b required 1", enable_n);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    btn      = 1'b1;
    tick     = 1'b0;
    flag     = 1'b1;
    test_reset();
    test_hold_through_reset();
    test_short_press_run();
    test_long_press_run();
    test_flag_idle();
    test_flag_tick();
    test_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
